// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, default widths and arbiter helpers.
// ALU_ARB_RR_EN selects round-robin (defined) or fixed priority (undefined) in the arbiter.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd8
  } alu_fn_t;

  localparam int XLEN_DEF = 32;
  localparam int NREQ_MAX = 8;

  typedef logic [$clog2(NREQ_MAX)-1:0] arb_id_t;

  function automatic int next_ptr(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// Requester and result handshake bundle for the shared-ALU arbiter.
interface alu_share_arb_if
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int XLEN = XLEN_DEF,
  parameter int ID_W = $clog2(NREQ)
);
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ-1:0][3:0]      req_fn;
  logic [NREQ-1:0][XLEN-1:0] req_a;
  logic [NREQ-1:0][XLEN-1:0] req_b;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [XLEN-1:0]           rsp_result;
  logic [ID_W-1:0]           rsp_id;

  modport master (
    output req_valid, req_fn, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_id
  );

  modport slave (
    input  req_valid, req_fn, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_id
  );
endinterface

// File: rtl/alu.sv
// Single-cycle combinational ALU: add and subtract modulo 2^XLEN, zero for other codes.
module alu
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  alu_fn_t         fn,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);
  always_comb begin
    case (fn)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/arb_pick.sv
// Combinational grant picker producing a one-hot grant and its index.
// ALU_ARB_RR_EN: search starts at ptr (round-robin); otherwise lowest index wins.
module arb_pick #(
  parameter int NREQ = 2,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
`ifdef ALU_ARB_RR_EN
  input  logic [ID_W-1:0] ptr,
`endif
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] idx
);
  logic found;

`ifdef ALU_ARB_RR_EN
  int c;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < NREQ; k++) begin
      c = (int'(ptr) + k) % NREQ;
      if (!found && valid[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        idx    = ID_W'(c);
      end
    end
  end
`else
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && valid[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = ID_W'(k);
      end
    end
  end
`endif
endmodule

// File: rtl/alu_share_arb.sv
// Arbitrates NREQ requesters onto one ALU with a one-entry registered result.
// ALU_ARB_RR_EN enables the round-robin pointer; undefined gives fixed priority.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int XLEN = XLEN_DEF,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            nrst,
  alu_share_arb_if.slave  bus
);
  if (NREQ < 2 || NREQ > NREQ_MAX) begin : g_bad_nreq
    $error("alu_share_arb: NREQ out of range");
  end

  logic [NREQ-1:0] gnt;
  logic [ID_W-1:0] idx;
  logic            slot_free;
  logic            accept;
  alu_fn_t         alu_fn;
  logic [XLEN-1:0] alu_a, alu_b, alu_y;
  logic            rsp_valid_q;
  logic [XLEN-1:0] rsp_result_q;
  logic [ID_W-1:0] rsp_id_q;

`ifdef ALU_ARB_RR_EN
  logic [ID_W-1:0] ptr_q;

  arb_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
    .valid (bus.req_valid),
    .ptr   (ptr_q),
    .gnt   (gnt),
    .idx   (idx)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)       ptr_q <= '0;
    else if (accept) ptr_q <= ID_W'(next_ptr(int'(idx), NREQ));
  end
`else
  arb_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
    .valid (bus.req_valid),
    .gnt   (gnt),
    .idx   (idx)
  );
`endif

  // Gating with nrst keeps requesters from seeing a grant that reset would swallow.
  assign slot_free     = nrst && (!rsp_valid_q || bus.rsp_ready);
  assign accept        = slot_free && (|gnt);
  assign bus.req_ready = slot_free ? gnt : '0;

  always_comb begin
    alu_fn = ALU_ADD;
    alu_a  = '0;
    alu_b  = '0;
    if (accept) begin
      alu_fn = alu_fn_t'(bus.req_fn[idx]);
      alu_a  = bus.req_a[idx];
      alu_b  = bus.req_b[idx];
    end
  end

  alu #(.XLEN(XLEN)) u_alu (
    .fn (alu_fn),
    .a  (alu_a),
    .b  (alu_b),
    .y  (alu_y)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_id_q     <= '0;
    end else if (accept) begin
      rsp_valid_q  <= 1'b1;
      rsp_result_q <= alu_y;
      rsp_id_q     <= idx;
    end else if (bus.rsp_ready) begin
      rsp_valid_q  <= 1'b0;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_id     = rsp_id_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed test of alu_share_arb with two requesters; expectations follow ALU_ARB_RR_EN.
module tb_alu_share_arb;
  localparam int NREQ = 2;
  localparam int XLEN = 32;

  logic clk;
  logic nrst;
  int   n_chk;
  int   n_fail;

  alu_share_arb_if #(.NREQ(NREQ), .XLEN(XLEN)) bus ();

  alu_share_arb #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] fn,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    bus.req_valid[i] = v;
    bus.req_fn[i]    = fn;
    bus.req_a[i]     = a;
    bus.req_b[i]     = b;
  endtask

  // Payload must stay stable while a request is waiting for acceptance.
  logic [NREQ-1:0]           pv, pr;
  logic [NREQ-1:0][3:0]      pfn;
  logic [NREQ-1:0][XLEN-1:0] pa, pb;
  initial begin
    pv = '0;
    pr = '0;
  end
  always @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (nrst && pv[i] && !pr[i] && bus.req_valid[i])
        assert (bus.req_fn[i] == pfn[i] && bus.req_a[i] == pa[i] && bus.req_b[i] == pb[i])
          else $error("payload changed while waiting, requester %0d", i);
    end
    pv  = bus.req_valid;
    pr  = bus.req_ready;
    pfn = bus.req_fn;
    pa  = bus.req_a;
    pb  = bus.req_b;
  end

  logic [1:0] exp_gnt [4];
  logic       exp_id  [4];
  logic [31:0] exp_res [4];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    nrst   = 1'b0;
    bus.req_valid = '0;
    bus.req_fn    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
`ifdef ALU_ARB_RR_EN
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_id  = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_res = '{32'd11, 32'd22, 32'd11, 32'd22};
`else
    exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01};
    exp_id  = '{1'b0, 1'b0, 1'b0, 1'b0};
    exp_res = '{32'd11, 32'd11, 32'd11, 32'd11};
`endif

    tick();
    tick();
    chk("rst_valid",  bus.rsp_valid, 0);
    chk("rst_result", bus.rsp_result, 0);
    chk("rst_id",     bus.rsp_id, 0);
    chk("rst_ready",  bus.req_ready, 0);
    nrst = 1'b1;
    tick();

    // Single add from requester 0
    set_req(0, 1'b1, 4'd0, 32'd5, 32'd7);
    bus.rsp_ready = 1'b1;
    #1 chk("add_ready", bus.req_ready, 2'b01);
    tick();
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    chk("add_valid",  bus.rsp_valid, 1);
    chk("add_result", bus.rsp_result, 32'd12);
    chk("add_id",     bus.rsp_id, 0);
    #1 chk("idle_ready", bus.req_ready, 2'b00);

    // Subtract wrap from requester 1
    set_req(1, 1'b1, 4'd8, 32'd0, 32'd1);
    #1 chk("sub_ready", bus.req_ready, 2'b10);
    tick();
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    chk("sub_result", bus.rsp_result, 32'hFFFF_FFFF);
    chk("sub_id",     bus.rsp_id, 1);
    chk("sub_valid",  bus.rsp_valid, 1);
    tick();
    chk("drain_valid", bus.rsp_valid, 0);
    chk("drain_hold",  bus.rsp_result, 32'hFFFF_FFFF);

    // Contention
    set_req(0, 1'b1, 4'd0, 32'd10, 32'd1);
    set_req(1, 1'b1, 4'd0, 32'd20, 32'd2);
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("cont_ready%0d", k), bus.req_ready, exp_gnt[k]);
      tick();
      chk($sformatf("cont_id%0d", k),  bus.rsp_id, exp_id[k]);
      chk($sformatf("cont_res%0d", k), bus.rsp_result, exp_res[k]);
    end

    // Backpressure for three cycles, then drain+accept together
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("bp_ready%0d", k), bus.req_ready, 2'b00);
      tick();
      chk($sformatf("bp_hold%0d", k),  bus.rsp_result, exp_res[3]);
      chk($sformatf("bp_valid%0d", k), bus.rsp_valid, 1);
    end
    bus.rsp_ready = 1'b1;
    #1 chk("bp_release_ready", bus.req_ready, 2'b01);
    tick();
    chk("bp_release_valid", bus.rsp_valid, 1);
    chk("bp_release_id",    bus.rsp_id, 0);
    chk("bp_release_res",   bus.rsp_result, 32'd11);

    // Unsupported function code
    set_req(0, 1'b1, 4'd3, 32'd9, 32'd4);
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    #1 chk("unsup_ready", bus.req_ready, 2'b01);
    tick();
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    chk("unsup_result", bus.rsp_result, 0);
    chk("unsup_valid",  bus.rsp_valid, 1);

    // Reset while a result is pending
    bus.rsp_ready = 1'b0;
    #2 nrst = 1'b0;
    set_req(0, 1'b1, 4'd0, 32'd10, 32'd1);
    set_req(1, 1'b1, 4'd0, 32'd20, 32'd2);
    #1 chk("mrst_valid", bus.rsp_valid, 0);
    chk("mrst_ready", bus.req_ready, 2'b00);
    tick();
    nrst = 1'b1;
    bus.rsp_ready = 1'b1;
    #1 chk("post_rst_ready", bus.req_ready, 2'b01);
    tick();
    chk("post_rst_id",  bus.rsp_id, 0);
    chk("post_rst_res", bus.rsp_result, 32'd11);
`ifdef ALU_ARB_RR_EN
    #1 chk("post_rst_next", bus.req_ready, 2'b10);
`else
    #1 chk("post_rst_next", bus.req_ready, 2'b01);
`endif
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
